// File: rtl/ifid_queue_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
package ifid_queue_pkg;

  localparam int          IFID_DEPTH = 2;
  localparam logic [15:0] NOP_INSTR  = 16'h0800;
  localparam logic [15:0] HALT_INSTR = 16'h0000;

  typedef struct packed {
    logic [15:0] pc_next;
    logic [15:0] instr;
    logic        err;
  } ifid_entry_t;

  // A fetch error is stored as a halt word so decode stops on it.
  function automatic ifid_entry_t mk_entry(input logic [15:0] pc_next,
                                           input logic [15:0] instr,
                                           input logic        err);
    ifid_entry_t e;
    e.pc_next = pc_next;
    e.instr   = err ? HALT_INSTR : instr;
    e.err     = err;
    return e;
  endfunction

endpackage

// File: rtl/ifid_queue_ptr_ctrl.sv
// Pointer/count/halt control for the two-entry IF/ID queue.
// Optional same-cycle bypass when empty: define IFID_BYPASS_EN.
module ifid_ptr_ctrl
  import ifid_queue_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       f_valid,
  input  logic       d_ready,
  input  logic       flush,
  input  logic       enq_halt,
  output logic       f_ready,
  output logic       d_valid,
  output logic       byp,
  output logic       wr_en,
  output logic       wr_ptr,
  output logic       rd_ptr,
  output logic [1:0] count,
  output logic       halt_latched
);

  logic       enq, deq, rd_adv;
  logic [1:0] count_nxt;

  // f_ready depends only on state and flush, never on d_ready.
  assign f_ready = (count != 2'd2) & ~halt_latched & ~flush;
  assign enq     = f_valid & f_ready;

`ifdef IFID_BYPASS_EN
  assign byp = enq & (count == 2'd0);
`else
  assign byp = 1'b0;
`endif

  assign d_valid   = (count != 2'd0) | byp;
  assign deq       = d_valid & d_ready;
  assign wr_en     = enq & ~(byp & d_ready);
  assign rd_adv    = deq & (count != 2'd0);
  assign count_nxt = count + 2'(enq) - 2'(deq);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      halt_latched <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= ~wr_ptr;
      if (rd_adv) rd_ptr <= ~rd_ptr;
      count <= count_nxt;
      if (enq && enq_halt) halt_latched <= 1'b1;
    end
  end

endmodule

// File: rtl/ifid_queue.sv
// Two-entry instruction queue between fetch and decode (replaces IF/ID reg).
// Optional same-cycle bypass when empty: define IFID_BYPASS_EN.
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int DEPTH = IFID_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic [15:0] f_pc_next,
  input  logic [15:0] f_instr,
  input  logic        f_err,
  output logic        f_ready,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [15:0] d_instr,
  output logic [15:0] d_pc_next,
  output logic        d_err,
  input  logic        flush,
  output logic        halt_seen
);

  ifid_entry_t mem [DEPTH];
  ifid_entry_t in_entry, head;
  logic        byp, wr_en, wr_ptr, rd_ptr, halt_latched;
  logic [1:0]  count;

  assign in_entry = mk_entry(f_pc_next, f_instr, f_err);

  ifid_ptr_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .f_valid      (f_valid),
    .d_ready      (d_ready),
    .flush        (flush),
    .enq_halt     (in_entry.instr == HALT_INSTR),
    .f_ready      (f_ready),
    .d_valid      (d_valid),
    .byp          (byp),
    .wr_en        (wr_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .halt_latched (halt_latched)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Empty queue shows a NOP; byp is constant 0 unless bypass is built in.
  always_comb begin
    head.pc_next = 16'h0000;
    head.instr   = NOP_INSTR;
    head.err     = 1'b0;
    if (byp)                 head = in_entry;
    else if (count != 2'd0)  head = mem[rd_ptr];
  end

  assign d_instr   = head.instr;
  assign d_pc_next = head.pc_next;
  assign d_err     = head.err;
  assign halt_seen = halt_latched;

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: vector table plus a queue-based reference model.
module tb_ifid_queue;
  import ifid_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid = 1'b0, f_err = 1'b0, d_ready = 1'b0, flush = 1'b0;
  logic [15:0] f_pc_next = '0, f_instr = '0;
  logic        f_ready, d_valid, d_err, halt_seen;
  logic [15:0] d_instr, d_pc_next;

  int tot = 0;
  int bad = 0;

  ifid_queue dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc_next(f_pc_next),
    .f_instr(f_instr), .f_err(f_err), .f_ready(f_ready), .d_ready(d_ready),
    .d_valid(d_valid), .d_instr(d_instr), .d_pc_next(d_pc_next), .d_err(d_err),
    .flush(flush), .halt_seen(halt_seen)
  );

  always #5 clk = ~clk;

  // Reference model state
  ifid_entry_t mq[$];
  logic        mhalt = 1'b0;

  typedef struct {
    logic        fv;
    logic [15:0] ins;
    logic        er, dr, fl, rs;
    logic        edv;
    logic [15:0] edi;
    logic        efr, ehs;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t v(input logic fv, input logic [15:0] ins,
                             input logic er, dr, fl, rs, edv,
                             input logic [15:0] edi, input logic efr, ehs);
    vec_t t;
    t.fv = fv; t.ins = ins; t.er = er; t.dr = dr; t.fl = fl; t.rs = rs;
    t.edv = edv; t.edi = edi; t.efr = efr; t.ehs = ehs;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [15:0] pc, input logic [15:0] ins,
                       input logic er, dr, fl, rs);
    @(negedge clk);
    f_valid = fv; f_pc_next = pc; f_instr = ins; f_err = er;
    d_ready = dr; flush = fl; rst = rs;
    #1;
  endtask

  // Compare DUT against the model for the current inputs, then advance the model.
  task automatic model_step();
    logic        efr, enq, bypass, edv;
    ifid_entry_t e, hd;
    efr = (mq.size() != 2) && !mhalt && !flush;
    enq = f_valid && efr;
    e.pc_next = f_pc_next;
    e.instr   = f_err ? 16'h0000 : f_instr;
    e.err     = f_err;
`ifdef IFID_BYPASS_EN
    bypass = enq && (mq.size() == 0);
`else
    bypass = 1'b0;
`endif
    edv = (mq.size() != 0) || bypass;
    if (bypass)           hd = e;
    else if (edv)         hd = mq[0];
    else begin hd.pc_next = 16'h0000; hd.instr = 16'h0800; hd.err = 1'b0; end
    chk("count",     32'(dut.u_ctrl.count), 32'(mq.size()));
    chk("f_ready",   32'(f_ready),   32'(efr));
    chk("d_valid",   32'(d_valid),   32'(edv));
    chk("d_instr",   32'(d_instr),   32'(hd.instr));
    chk("d_pc_next", 32'(d_pc_next), 32'(hd.pc_next));
    chk("d_err",     32'(d_err),     32'(hd.err));
    chk("halt_seen", 32'(halt_seen), 32'(mhalt));
    if (rst || flush) begin
      mq.delete();
      mhalt = 1'b0;
    end else begin
      if (!(bypass && d_ready)) begin
        if (edv && d_ready) void'(mq.pop_front());
        if (enq) mq.push_back(e);
      end
      if (enq && e.instr == 16'h0000) mhalt = 1'b1;
    end
  endtask

  initial begin
    tbl[0]  = v(1, 16'h1111, 0, 1, 0, 0, 0, 16'h0800, 1, 0);
    tbl[1]  = v(1, 16'h2222, 0, 1, 0, 0, 1, 16'h1111, 1, 0);
    tbl[2]  = v(1, 16'h3333, 0, 1, 0, 0, 1, 16'h2222, 1, 0);
    tbl[3]  = v(0, 16'h0000, 0, 1, 0, 0, 1, 16'h3333, 1, 0);
    tbl[4]  = v(1, 16'hA001, 0, 0, 0, 0, 0, 16'h0800, 1, 0);
    tbl[5]  = v(1, 16'hA002, 0, 0, 0, 0, 1, 16'hA001, 1, 0);
    tbl[6]  = v(1, 16'hBEEF, 0, 0, 0, 0, 1, 16'hA001, 0, 0);
    tbl[7]  = v(0, 16'h0000, 0, 1, 0, 0, 1, 16'hA001, 0, 0);
    tbl[8]  = v(0, 16'h0000, 0, 1, 0, 0, 1, 16'hA002, 1, 0);
    tbl[9]  = v(0, 16'h0000, 0, 1, 0, 0, 0, 16'h0800, 1, 0);
    tbl[10] = v(1, 16'hC001, 0, 0, 0, 0, 0, 16'h0800, 1, 0);
    tbl[11] = v(1, 16'hC002, 0, 0, 0, 0, 1, 16'hC001, 1, 0);
    tbl[12] = v(1, 16'hDEAD, 0, 0, 1, 0, 1, 16'hC001, 0, 0);
    tbl[13] = v(0, 16'h0000, 0, 1, 0, 0, 0, 16'h0800, 1, 0);
    tbl[14] = v(1, 16'h4444, 0, 0, 0, 0, 0, 16'h0800, 1, 0);
    tbl[15] = v(1, 16'h0000, 0, 0, 0, 0, 1, 16'h4444, 1, 0);
    tbl[16] = v(1, 16'h7777, 0, 1, 0, 0, 1, 16'h4444, 0, 1);
    tbl[17] = v(0, 16'h0000, 0, 1, 0, 0, 1, 16'h0000, 0, 1);
    tbl[18] = v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0800, 0, 1);
    tbl[19] = v(0, 16'h0000, 0, 0, 1, 0, 0, 16'h0800, 0, 1);
    tbl[20] = v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0800, 1, 0);
    tbl[21] = v(1, 16'h5555, 1, 0, 0, 0, 0, 16'h0800, 1, 0);
    tbl[22] = v(0, 16'h0000, 0, 1, 0, 0, 1, 16'h0000, 0, 1);
    tbl[23] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0800, 0, 1);
    tbl[24] = v(1, 16'hE001, 0, 0, 0, 0, 0, 16'h0800, 1, 0);
    tbl[25] = v(1, 16'hE002, 0, 0, 0, 0, 1, 16'hE001, 1, 0);
    tbl[26] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'hE001, 0, 0);
    tbl[27] = v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0800, 1, 0);

    // Bring storage out of X before the first checked cycle.
    rst = 1'b1;
    @(posedge clk);

    drive(0, 16'h0, 16'h0, 0, 0, 0, 1);
    model_step();

    foreach (tbl[i]) begin
      drive(tbl[i].fv, tbl[i].ins ^ 16'h0F0F, tbl[i].ins,
            tbl[i].er, tbl[i].dr, tbl[i].fl, tbl[i].rs);
`ifndef IFID_BYPASS_EN
      chk($sformatf("v%0d.d_valid", i),   32'(d_valid),   32'(tbl[i].edv));
      chk($sformatf("v%0d.d_instr", i),   32'(d_instr),   32'(tbl[i].edi));
      chk($sformatf("v%0d.f_ready", i),   32'(f_ready),   32'(tbl[i].efr));
      chk($sformatf("v%0d.halt_seen", i), 32'(halt_seen), 32'(tbl[i].ehs));
`endif
      model_step();
    end

    // Empty queue, valid fetch with decode ready.
    drive(1, 16'h6668, 16'h6666, 0, 1, 0, 0);
`ifdef IFID_BYPASS_EN
    chk("byp.d_valid", 32'(d_valid), 32'd1);
    chk("byp.d_instr", 32'(d_instr), 32'h6666);
`else
    chk("nobyp.d_valid", 32'(d_valid), 32'd0);
    chk("nobyp.d_instr", 32'(d_instr), 32'h0800);
`endif
    model_step();
    drive(0, 16'h0, 16'h0, 0, 1, 0, 0);
`ifdef IFID_BYPASS_EN
    chk("byp.count_after", 32'(dut.u_ctrl.count), 32'd0);
`else
    chk("nobyp.d_instr_next", 32'(d_instr), 32'h6666);
`endif
    model_step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ins;
      ins = ($urandom_range(0, 19) == 0) ? 16'h0000 : 16'($urandom);
      drive($urandom_range(0, 9) < 7, 16'($urandom), ins,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
            $urandom_range(0, 11) == 0, $urandom_range(0, 49) == 0);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
